// File: rtl/truth_table_sweep_if.sv
// truth_table_sweep_if: stimulus/capture bus of truth_table_sweep
// TT_SIGNATURE_EN adds the ones popcount signal
interface truth_table_sweep_if #(
  parameter int N_IN = 7
);
  logic start, busy, f_in, tt_valid, tt_ready;
  logic [N_IN-1:0] x;
  logic [2**N_IN-1:0] tt;
`ifdef TT_SIGNATURE_EN
  logic [N_IN:0] ones;
  modport master (input start, f_in, tt_ready, output busy, x, tt, tt_valid, ones);
  modport slave (output start, f_in, tt_ready, input busy, x, tt, tt_valid, ones);
`else
  modport master (input start, f_in, tt_ready, output busy, x, tt, tt_valid);
  modport slave (output start, f_in, tt_ready, input busy, x, tt, tt_valid);
`endif
endinterface

// File: rtl/truth_table_sweep.sv
// truth_table_sweep: drives every input vector, captures f_in into a truth table, offers it valid/ready
// TT_SIGNATURE_EN adds a running popcount of captured ones
module truth_table_sweep #(
  parameter int N_IN = 7,
  parameter int LAT = 0
) (
  input logic clk,
  input logic rst_n,
  truth_table_sweep_if.master bus
);
  localparam int TT_W = 2**N_IN;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, HOLD} state_t;
  state_t state, state_n;
  logic [N_IN-1:0] idx, cap_i;
  logic [TT_W-1:0] tt;
  logic tt_valid, cap_v, last, done, accept;
  assign last = idx == N_IN'(TT_W - 1);
  assign done = tt_valid && bus.tt_ready;
  assign accept = bus.start && (state == IDLE || (state == HOLD && done));
  always_comb begin
    state_n = accept ? SWEEP
      : state == SWEEP && last ? (LAT > 0 ? DRAIN : HOLD)
      : state == DRAIN && cap_v && cap_i == N_IN'(TT_W - 1) ? HOLD
      : state == HOLD && done ? IDLE
      : state;
  end
  // idx wraps to 0 exactly as SWEEP is left, so x is 0 everywhere else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      tt <= '0;
      tt_valid <= 1'b0;
    end else begin
      state <= state_n;
      idx <= state == SWEEP ? idx + 1'b1 : '0;
      tt_valid <= state == HOLD && !done;
      if (accept) tt <= '0;
      else if (cap_v) tt[cap_i] <= bus.f_in;
    end
  if (LAT == 0) begin : g_direct
    assign cap_v = state == SWEEP;
    assign cap_i = idx;
  end else begin : g_delay
    logic [LAT-1:0] v_sr;
    logic [N_IN-1:0] i_sr [LAT];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_sr <= '0;
        for (int j = 0; j < LAT; j++) i_sr[j] <= '0;
      end else begin
        v_sr[0] <= state == SWEEP;
        i_sr[0] <= idx;
        for (int j = 1; j < LAT; j++) begin
          v_sr[j] <= v_sr[j-1];
          i_sr[j] <= i_sr[j-1];
        end
      end
    assign cap_v = v_sr[LAT-1];
    assign cap_i = i_sr[LAT-1];
  end
`ifdef TT_SIGNATURE_EN
  logic [N_IN:0] ones;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ones <= '0;
    else if (accept) ones <= '0;
    else if (cap_v && bus.f_in) ones <= ones + 1'b1;
  assign bus.ones = ones;
`endif
  assign bus.busy = state == SWEEP || state == DRAIN;
  assign bus.x = idx;
  assign bus.tt = tt;
  assign bus.tt_valid = tt_valid;
endmodule

// File: tb/tb_truth_table_sweep.sv
// tb_truth_table_sweep: two instances (LAT=0 and LAT=2) checked against a sweep-timing model
module tb_truth_table_sweep;
  localparam int TT_W = 128;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  truth_table_sweep_if #(.N_IN(7)) b0 ();
  truth_table_sweep_if #(.N_IN(7)) b1 ();
  truth_table_sweep #(.N_IN(7), .LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  truth_table_sweep #(.N_IN(7), .LAT(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  logic st [2], rdy [2], act [2];
  logic [127:0] fn [2], rtt [2];
  int n [2];
  logic p1, p2;
  int checks = 0, errors = 0;
  logic [6:0] d_x [2];
  logic d_busy [2], d_v [2];
  logic [127:0] d_tt [2];
  assign b0.start = st[0];
  assign b1.start = st[1];
  assign b0.tt_ready = rdy[0];
  assign b1.tt_ready = rdy[1];
  assign b0.f_in = fn[0][b0.x];
  always @(posedge clk) begin
    p1 <= fn[1][b1.x];
    p2 <= p1;
  end
  assign b1.f_in = p2;
  assign d_x[0] = b0.x;
  assign d_x[1] = b1.x;
  assign d_busy[0] = b0.busy;
  assign d_busy[1] = b1.busy;
  assign d_v[0] = b0.tt_valid;
  assign d_v[1] = b1.tt_valid;
  assign d_tt[0] = b0.tt;
  assign d_tt[1] = b1.tt;
`ifdef TT_SIGNATURE_EN
  logic [7:0] d_ones [2];
  assign d_ones[0] = b0.ones;
  assign d_ones[1] = b1.ones;
`endif
  function automatic int lat_of(input int i);
    return 2 * i;
  endfunction
  // n counts edges since the accepting edge: x=n while n<TT_W, sample k lands on edge k+1+LAT
  function automatic logic [6:0] e_x(input int i);
    return (act[i] && n[i] < TT_W) ? 7'(n[i]) : 7'd0;
  endfunction
  function automatic logic e_busy(input int i);
    return act[i] && n[i] < TT_W + lat_of(i);
  endfunction
  function automatic logic e_v(input int i);
    return act[i] && n[i] > TT_W + lat_of(i);
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        act[i] <= 1'b0;
        n[i] <= 0;
        rtt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        if (st[i] && (!act[i] || (e_v(i) && rdy[i]))) begin
          act[i] <= 1'b1;
          n[i] <= 0;
          rtt[i] <= '0;
        end else if (e_v(i) && rdy[i]) act[i] <= 1'b0;
        else if (act[i]) begin
          n[i] <= n[i] + 1;
          if (n[i] >= lat_of(i) && n[i] - lat_of(i) < TT_W)
            rtt[i][7'(n[i] - lat_of(i))] <= fn[i][7'(n[i] - lat_of(i))];
        end
    end
  task automatic chk(input string nm, input int i, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, i, a, e);
    end
  endtask
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("x", i, 128'(d_x[i]), 128'(e_x(i)));
      chk("busy", i, 128'(d_busy[i]), 128'(e_busy(i)));
      chk("tt_valid", i, 128'(d_v[i]), 128'(e_v(i)));
      chk("tt", i, d_tt[i], rtt[i]);
`ifdef TT_SIGNATURE_EN
      chk("ones", i, 128'(d_ones[i]), 128'($countones(rtt[i])));
`endif
    end
  end
  task automatic run(input int i, input logic [127:0] f, input logic r);
    fn[i] = f;
    st[i] = 1'b1;
    rdy[i] = r;
    @(negedge clk);
    st[i] = 1'b0;
    rdy[i] = 1'b0;
  endtask
  task automatic wait_valid(input int i, input int exp_lat);
    int c = 0;
    while (!d_v[i] && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("latency", i, 128'(c), 128'(exp_lat));
  endtask
  task automatic pin(input int i, input logic [127:0] e, input int o);
    chk("tt_lit", i, d_tt[i], e);
`ifdef TT_SIGNATURE_EN
    chk("ones_lit", i, 128'(d_ones[i]), 128'(o));
`else
    if (o < 0) $display("negative popcount %0d", o);
`endif
  endtask
  task automatic ack(input int i);
    rdy[i] = 1'b1;
    @(negedge clk);
    rdy[i] = 1'b0;
    chk("ack_valid", i, 128'(d_v[i]), 128'(0));
    chk("ack_busy", i, 128'(d_busy[i]), 128'(0));
  endtask
  task automatic zeros(input int i);
    chk("rst_x", i, 128'(d_x[i]), 128'(0));
    chk("rst_busy", i, 128'(d_busy[i]), 128'(0));
    chk("rst_valid", i, 128'(d_v[i]), 128'(0));
    chk("rst_tt", i, d_tt[i], 128'(0));
`ifdef TT_SIGNATURE_EN
    chk("rst_ones", i, 128'(d_ones[i]), 128'(0));
`endif
  endtask
  initial begin
    logic [127:0] fx0, fand, fn6, rf;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0;
      rdy[i] = 1'b0;
      fn[i] = '0;
    end
    for (int k = 0; k < TT_W; k++) begin
      fx0[k] = k[0];
      fand[k] = &7'(k);
      fn6[k] = !k[6];
    end
    #1 rst_n = 1'b0;
    #12;
    zeros(0);
    zeros(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      run(i, fx0, 1'b0);
      wait_valid(i, i == 1 ? 131 : 129);
      pin(i, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 64);
      ack(i);
      run(i, fand, 1'b0);
      wait_valid(i, i == 1 ? 131 : 129);
      pin(i, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1);
      repeat (20) begin
        st[i] = 1'($urandom);
        @(negedge clk);
      end
      st[i] = 1'b0;
      pin(i, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1);
      chk("hold_valid", i, 128'(d_v[i]), 128'(1));
      chk("hold_busy", i, 128'(d_busy[i]), 128'(0));
      run(i, fn6, 1'b1);
      chk("b2b_valid", i, 128'(d_v[i]), 128'(0));
      chk("b2b_busy", i, 128'(d_busy[i]), 128'(1));
      wait_valid(i, i == 1 ? 131 : 129);
      pin(i, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 64);
      ack(i);
      rf = {$urandom, $urandom, $urandom, $urandom};
      run(i, rf, 1'b0);
      repeat (57) @(negedge clk);
      chk("x57", i, 128'(d_x[i]), 128'(57));
      #2 rst_n = 1'b0;
      #1;
      zeros(i);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rf = {$urandom, $urandom, $urandom, $urandom};
      run(i, rf, 1'b0);
      wait_valid(i, i == 1 ? 131 : 129);
      pin(i, rf, $countones(rf));
      ack(i);
      repeat (2) begin
        rf = {$urandom, $urandom, $urandom, $urandom};
        run(i, rf, 1'b0);
        wait_valid(i, i == 1 ? 131 : 129);
        pin(i, rf, $countones(rf));
        repeat ($urandom_range(0, 5)) @(negedge clk);
        ack(i);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
